pipelined_interval_timer: RTL and testbench

Programmable interval timer built on the chunked carry-chain counter and pipelined equality tree, with a latched period register, periodic and one-shot modes, and run control. It sits between a tick source (`enable`) and event consumers. It adds what the bare strobe counter lacks: a shadow period reload at terminal count, start/stop/done control, a coherent count readback, and overrun detection for ticks presented while the pipeline is still settling.

---
 rtl/pipelined_interval_timer_pkg.sv | 35 +++
 rtl/pipelined_interval_timer_equality_tree.sv | 37 +++
 rtl/pipelined_interval_timer.sv | 153 +++++++++++++++
 tb/tb_pipelined_interval_timer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_interval_timer_pkg.sv
// Shared definitions for the interval timer: FSM encoding and the chunk
// geometry helpers used by both the counter and the equality tree.
package pipelined_interval_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } timer_state_e;

  // Bits per carry-chain chunk; a latency budget of one keeps a single chunk.
  function automatic int chunk_width(input int width, input int latency);
    if (latency <= 1) return width;
    return (width + latency - 1) / latency;
  endfunction

  // Number of chunks needed to cover the full width.
  function automatic int chunk_count(input int width, input int latency);
    int cw;
    cw = chunk_width(width, latency);
    return (width + cw - 1) / cw;
  endfunction

  // Width of the most significant chunk (may be narrower than the others).
  function automatic int last_chunk_width(input int width, input int latency);
    return width - chunk_width(width, latency) * (chunk_count(width, latency) - 1);
  endfunction

  // Cycles for the carry chain to ripple plus one for the registered compares.
  function automatic int settle_cycles(input int width, input int latency);
    if (latency <= 1) return 0;
    return chunk_count(width, latency) + 1;
  endfunction

endpackage

// File: rtl/pipelined_interval_timer_equality_tree.sv
// Chunked equality compare: one registered compare per counter chunk,
// reduced by an AND tree. With a single-cycle budget the compare is direct.
module pipelined_interval_timer_equality_tree
  import pipelined_interval_timer_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq
);

  localparam int CW = chunk_width(WIDTH, LATENCY);
  localparam int CC = chunk_count(WIDTH, LATENCY);
  localparam int LW = last_chunk_width(WIDTH, LATENCY);

  logic [CC-1:0] cmp_d;
  logic [CC-1:0] cmp_q;

  for (genvar k = 0; k < CC; k++) begin : g_cmp
    localparam int LO = k * CW;
    localparam int KW = (k == CC - 1) ? LW : CW;
    assign cmp_d[k] = (a[LO +: KW] == b[LO +: KW]);
  end

  // Register the per-chunk compares so the AND tree sees settled chunk values.
  always_ff @(posedge clk) begin
    if (rst) cmp_q <= '0;
    else     cmp_q <= cmp_d;
  end

  assign eq = (LATENCY <= 1) ? &cmp_d : &cmp_q;

endmodule

// File: rtl/pipelined_interval_timer.sv
// Programmable interval timer: chunked carry-chain tick counter, shadow
// period register reloaded at terminal count, periodic/one-shot modes,
// start/stop control and overrun detection.
//
// Tick handshake: `enable` is a request and `ready` an acceptance. A tick
// transfers only on a cycle where enable && ready; a request while ready is
// low is dropped (never queued) and, in RUN, raises the sticky overrun flag.
module pipelined_interval_timer
  import pipelined_interval_timer_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  input  logic             enable,
  output logic             strobe,
  output logic             ready,
  output logic             running,
  output logic             done,
  output logic             overrun,
  output logic [WIDTH-1:0] count,
  output timer_state_e     state_dbg
);

  localparam int CW     = chunk_width(WIDTH, LATENCY);
  localparam int CC     = chunk_count(WIDTH, LATENCY);
  localparam int LW     = last_chunk_width(WIDTH, LATENCY);
  localparam int SETTLE = settle_cycles(WIDTH, LATENCY);
  localparam int SCW    = $clog2(SETTLE + 2);

  timer_state_e     state_q;
  logic             running_q, done_q, strobe_q, overrun_q, mode_q;
  logic [WIDTH-1:0] active_q, shadow_q;
  logic [SCW-1:0]   settle_q;
  logic [WIDTH-1:0] count_w;
  logic [CC-1:0]    cin;
  logic             eq, go, tick, terminal, restart;

  // stop beats start; start (including a restart from RUN) beats a tick.
  assign go       = start && !stop;
  assign ready    = running_q && (settle_q == '0);
  assign tick     = ready && enable && !stop && !start;
  assign terminal = tick && eq;
  assign restart  = go || terminal;
  assign cin[0]   = tick && !eq;

  for (genvar k = 0; k < CC; k++) begin : g_chunk
    localparam int LO  = k * CW;
    localparam int CWK = (k == CC - 1) ? LW : CW;
    localparam int SW  = (k < CC - 1) ? CWK + 1 : CWK;
    logic [CWK-1:0] val_q;
    logic [SW-1:0]  sum;

    assign sum = SW'(val_q) + SW'(cin[k]);
    assign count_w[LO +: CWK] = val_q;

    // Chunk value: restart loads 1 (low chunk) / 0, otherwise absorb carry-in.
    always_ff @(posedge clk) begin
      if (rst || restart) val_q <= (k == 0) ? CWK'(1) : '0;
      else                val_q <= sum[CWK-1:0];
    end

    if (k < CC - 1) begin : g_carry
      logic co_q;
      // Registered carry into the next chunk; restart discards in-flight carries.
      always_ff @(posedge clk) begin
        if (rst || restart) co_q <= 1'b0;
        else                co_q <= sum[SW-1];
      end
      assign cin[k+1] = co_q;
    end
  end

  pipelined_interval_timer_equality_tree #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_eq (
    .clk (clk),
    .rst (rst),
    .a   (count_w),
    .b   (active_q),
    .eq  (eq)
  );

  // Control FSM with period registers, settle timer and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      strobe_q  <= 1'b0;
      overrun_q <= 1'b0;
      mode_q    <= 1'b0;
      active_q  <= '0;
      shadow_q  <= '0;
      settle_q  <= '0;
    end else begin
      strobe_q <= 1'b0;
      if (load) shadow_q <= period_in;
      if (stop) begin
        if (load && state_q != ST_RUN) active_q <= period_in;
        state_q   <= ST_IDLE;
        running_q <= 1'b0;
        done_q    <= 1'b0;
      end else if (start) begin
        state_q   <= ST_RUN;
        running_q <= 1'b1;
        done_q    <= 1'b0;
        overrun_q <= 1'b0;
        mode_q    <= mode;
        active_q  <= load ? period_in : shadow_q;
        settle_q  <= SCW'(SETTLE);
      end else begin
        case (state_q)
          ST_RUN: begin
            if (enable && !ready) overrun_q <= 1'b1;
            if (tick) begin
              settle_q <= SCW'(SETTLE);
              if (eq) begin
                strobe_q <= 1'b1;
                active_q <= shadow_q;
                if (mode_q) begin
                  state_q   <= ST_DONE;
                  running_q <= 1'b0;
                  done_q    <= 1'b1;
                end
              end
            end else if (settle_q != '0) begin
              settle_q <= settle_q - SCW'(1);
            end
          end
          default: begin
            if (load) active_q <= period_in;
          end
        endcase
      end
    end
  end

  assign strobe    = strobe_q;
  assign running   = running_q;
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign count     = count_w;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pipelined_interval_timer.sv
// Bench for pipelined_interval_timer: three instances (8-bit/LATENCY 1,
// 16-bit/LATENCY 4, 4-bit/LATENCY 3) share one set of inputs; a tick-count
// reference model predicts every output of every instance each cycle.
module tb_pipelined_interval_timer;
  import pipelined_interval_timer_pkg::*;

  localparam int NI = 3;

  // ---------------- clock / reset / inputs ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, stop, mode, load, enable;
  logic [31:0] period_in;

  logic strobe_a, ready_a, running_a, done_a, overrun_a;
  logic strobe_b, ready_b, running_b, done_b, overrun_b;
  logic strobe_c, ready_c, running_c, done_c, overrun_c;
  logic [7:0]  count_a;
  logic [15:0] count_b;
  logic [3:0]  count_c;
  timer_state_e state_a, state_b, state_c;

  pipelined_interval_timer #(.WIDTH(8), .LATENCY(1)) u_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .load(load),
    .period_in(period_in[7:0]), .enable(enable), .strobe(strobe_a), .ready(ready_a),
    .running(running_a), .done(done_a), .overrun(overrun_a), .count(count_a),
    .state_dbg(state_a));

  pipelined_interval_timer #(.WIDTH(16), .LATENCY(4)) u_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .load(load),
    .period_in(period_in[15:0]), .enable(enable), .strobe(strobe_b), .ready(ready_b),
    .running(running_b), .done(done_b), .overrun(overrun_b), .count(count_b),
    .state_dbg(state_b));

  pipelined_interval_timer #(.WIDTH(4), .LATENCY(3)) u_c (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .load(load),
    .period_in(period_in[3:0]), .enable(enable), .strobe(strobe_c), .ready(ready_c),
    .running(running_c), .done(done_c), .overrun(overrun_c), .count(count_c),
    .state_dbg(state_c));

  logic [NI-1:0] d_strobe, d_ready, d_running, d_done, d_overrun;
  logic [31:0]   d_count [NI];
  timer_state_e  d_state [NI];

  assign d_strobe  = {strobe_c, strobe_b, strobe_a};
  assign d_ready   = {ready_c, ready_b, ready_a};
  assign d_running = {running_c, running_b, running_a};
  assign d_done    = {done_c, done_b, done_a};
  assign d_overrun = {overrun_c, overrun_b, overrun_a};
  assign d_count[0] = {24'd0, count_a};
  assign d_count[1] = {16'd0, count_b};
  assign d_count[2] = {28'd0, count_c};
  assign d_state[0] = state_a;
  assign d_state[1] = state_b;
  assign d_state[2] = state_c;

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Timing: ready drops for SETTLE cycles after entry and after each accepted tick.
  function automatic int w_of(input int i);
    case (i)
      0:       return 8;
      1:       return 16;
      default: return 4;
    endcase
  endfunction

  function automatic int settle_of(input int i);
    case (i)
      0:       return 0;
      1:       return 5;
      default: return 3;
    endcase
  endfunction

  function automatic longint mask_of(input int i);
    return (longint'(1) << w_of(i)) - 1;
  endfunction

  bit     m_run [NI], m_done [NI], m_ovr [NI], m_strobe [NI], m_mode [NI];
  longint m_ticks [NI], m_active [NI], m_shadow [NI];
  int     m_wait [NI];

  task automatic model_step();
    longint pin, old_sh, eff;
    bit     rdy;
    for (int i = 0; i < NI; i++) begin
      pin    = longint'(period_in) & mask_of(i);
      old_sh = m_shadow[i];
      rdy    = m_run[i] && (m_wait[i] == 0);
      m_strobe[i] = 1'b0;
      if (rst) begin
        m_run[i] = 0; m_done[i] = 0; m_ovr[i] = 0; m_mode[i] = 0;
        m_ticks[i] = 0; m_active[i] = 0; m_shadow[i] = 0; m_wait[i] = 0;
      end else begin
        if (stop) begin
          if (load && !m_run[i]) m_active[i] = pin;
          m_run[i] = 0; m_done[i] = 0;
        end else if (start) begin
          m_run[i] = 1; m_done[i] = 0; m_ovr[i] = 0; m_mode[i] = mode;
          m_active[i] = load ? pin : old_sh;
          m_ticks[i] = 0; m_wait[i] = settle_of(i);
        end else if (m_run[i]) begin
          if (enable && !rdy) m_ovr[i] = 1;
          if (enable && rdy) begin
            eff = (m_active[i] == 0) ? mask_of(i) + 1 : m_active[i];
            m_wait[i] = settle_of(i);
            if (m_ticks[i] + 1 == eff) begin
              m_strobe[i] = 1; m_ticks[i] = 0; m_active[i] = old_sh;
              if (m_mode[i]) begin m_run[i] = 0; m_done[i] = 1; end
            end else begin
              m_ticks[i]++;
            end
          end else if (m_wait[i] > 0) begin
            m_wait[i]--;
          end
        end else if (load) begin
          m_active[i] = pin;
        end
        if (load) m_shadow[i] = pin;
      end
    end
  endtask

  task automatic check_all();
    bit er;
    timer_state_e es;
    for (int i = 0; i < NI; i++) begin
      er = m_run[i] && (m_wait[i] == 0);
      es = m_run[i] ? ST_RUN : (m_done[i] ? ST_DONE : ST_IDLE);
      check($sformatf("strobe[%0d]", i),  d_strobe[i],  m_strobe[i]);
      check($sformatf("ready[%0d]", i),   d_ready[i],   er);
      check($sformatf("running[%0d]", i), d_running[i], m_run[i]);
      check($sformatf("done[%0d]", i),    d_done[i],    m_done[i]);
      check($sformatf("overrun[%0d]", i), d_overrun[i], m_ovr[i]);
      check($sformatf("state[%0d]", i),   d_state[i],   es);
      if (er) check($sformatf("count[%0d]", i), d_count[i], (m_ticks[i] + 1) & mask_of(i));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; mode = 0; load = 0; enable = 0; period_in = '0;
  endtask

  // ---------------- directed table (instance a: 8-bit, LATENCY 1) ----------------
  typedef struct {
    bit          st, sp, md, ld;
    logic [31:0] per;
    bit          en;
    bit          e_run, e_rdy, e_str, e_done, chk;
  } vec_t;
  vec_t tbl[$];

  task automatic add_row(input bit st, sp, md, ld, input int per, input bit en,
                         input bit e_run, e_rdy, e_str, e_done, chk, input int e_cnt);
    vec_t v;
    v.st = st; v.sp = sp; v.md = md; v.ld = ld; v.per = per; v.en = en;
    v.e_run = e_run; v.e_rdy = e_rdy; v.e_str = e_str; v.e_done = e_done; v.chk = chk;
    tbl.push_back(v);
    if (chk) exp_q.push_back(32'(e_cnt));
  endtask

  task automatic fill_table();
    // periodic, period 5, enable held high
    add_row(0,0,0,1,5,0, 0,0,0,0, 1,1);
    add_row(1,0,0,0,0,0, 1,1,0,0, 1,1);
    for (int c = 2; c <= 5; c++) add_row(0,0,0,0,0,1, 1,1,0,0, 1,c);
    add_row(0,0,0,0,0,1, 1,1,1,0, 1,1);
    add_row(0,0,0,0,0,1, 1,1,0,0, 1,2);
    add_row(0,1,0,0,0,1, 0,0,0,0, 1,2);
    // one-shot, period 4
    add_row(0,0,0,1,4,0, 0,0,0,0, 1,2);
    add_row(1,0,1,0,0,0, 1,1,0,0, 1,1);
    for (int c = 2; c <= 4; c++) add_row(0,0,0,0,0,1, 1,1,0,0, 1,c);
    add_row(0,0,0,0,0,1, 0,0,1,1, 1,1);
    add_row(0,0,0,1,6,1, 0,0,0,1, 1,1);
    // re-arm periodic with period 6, shadow load of 2 mid-period
    add_row(1,0,0,0,0,0, 1,1,0,0, 1,1);
    for (int c = 2; c <= 4; c++) add_row(0,0,0,0,0,1, 1,1,0,0, 1,c);
    add_row(0,0,0,1,2,1, 1,1,0,0, 1,5);
    add_row(0,0,0,0,0,1, 1,1,0,0, 1,6);
    add_row(0,0,0,0,0,1, 1,1,1,0, 1,1);
    for (int r = 0; r < 2; r++) begin
      add_row(0,0,0,0,0,1, 1,1,0,0, 1,2);
      add_row(0,0,0,0,0,1, 1,1,1,0, 1,1);
    end
    add_row(0,1,0,0,0,0, 0,0,0,0, 0,0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int low, acc;
    bit seen, pre;
    logic [31:0] exp_cnt;

    rst = 1;
    idle_inputs();
    repeat (3) step();
    check("reset_count_a", count_a, 8'd1);
    check("reset_count_b", count_b, 16'd1);
    check("reset_count_c", count_c, 4'd1);
    rst = 0;
    step();

    fill_table();
    foreach (tbl[r]) begin
      start = tbl[r].st; stop = tbl[r].sp; mode = tbl[r].md; load = tbl[r].ld;
      period_in = tbl[r].per; enable = tbl[r].en;
      step();
      check($sformatf("tbl%0d_running", r), running_a, tbl[r].e_run);
      check($sformatf("tbl%0d_ready", r),   ready_a,   tbl[r].e_rdy);
      check($sformatf("tbl%0d_strobe", r),  strobe_a,  tbl[r].e_str);
      check($sformatf("tbl%0d_done", r),    done_a,    tbl[r].e_done);
      if (tbl[r].chk) begin
        exp_cnt = exp_q.pop_front();
        check($sformatf("tbl%0d_count", r), count_a, exp_cnt);
      end
    end
    idle_inputs();
    step();

    // pipelined instance b: period 3, enable only when ready
    load = 1; period_in = 3; step(); load = 0;
    start = 1; step(); start = 0;
    for (int t = 1; t <= 3; t++) begin
      low = 0;
      while (!ready_b && low < 40) begin step(); low++; end
      check($sformatf("pipe_gap%0d", t), low, 5);
      enable = 1; step(); enable = 0;
      check($sformatf("pipe_strobe%0d", t), strobe_b, (t == 3));
    end
    step();

    // overrun on b with enable held continuously; start clears it
    stop = 1; step(); stop = 0;
    load = 1; period_in = 4; step(); load = 0;
    start = 1; step(); start = 0;
    check("ovr_clear_after_start", overrun_b, 1'b0);
    enable = 1; step();
    check("ovr_set_in_settle", overrun_b, 1'b1);
    repeat (30) step();
    start = 1; step(); start = 0;
    check("ovr_cleared_by_start", overrun_b, 1'b0);
    enable = 0; step();

    // period 0 on c (4-bit): strobe after 16 accepted ticks
    stop = 1; step(); stop = 0;
    load = 1; period_in = 0; step(); load = 0;
    start = 1; step(); start = 0;
    enable = 1; acc = 0; seen = 0;
    for (int t = 0; t < 200 && !seen; t++) begin
      pre = ready_c;
      step();
      if (pre) acc++;
      if (strobe_c) seen = 1;
    end
    check("p0_strobe_seen", seen, 1'b1);
    check("p0_ticks", acc, 16);
    enable = 0; step();

    // stop together with the terminal tick on a: no strobe, back to idle
    stop = 1; step(); stop = 0;
    load = 1; period_in = 2; step(); load = 0;
    start = 1; step(); start = 0;
    enable = 1; step();
    stop = 1; step(); stop = 0; enable = 0;
    check("stop_term_strobe", strobe_a, 1'b0);
    check("stop_term_running", running_a, 1'b0);
    step();
    check("stop_term_strobe_late", strobe_a, 1'b0);

    // reset in the middle of RUN
    start = 1; step(); start = 0;
    enable = 1; repeat (7) step();
    rst = 1; step(); rst = 0; enable = 0;
    check("rst_mid_count_a", count_a, 8'd1);
    check("rst_mid_count_b", count_b, 16'd1);
    check("rst_mid_count_c", count_c, 4'd1);
    check("rst_mid_running_b", running_b, 1'b0);
    step();

    // randomized traffic against the model
    for (int t = 0; t < 500; t++) begin
      start     = ($urandom_range(0, 24) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      load      = ($urandom_range(0, 9) == 0);
      mode      = $urandom_range(0, 1);
      period_in = $urandom_range(0, 7);
      enable    = ($urandom_range(0, 3) != 0);
      step();
    end
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
